// File: rtl/cpu_control_gen.sv
// Control sequencer for a simple bus-based datapath: decodes load, move and ALU
// instructions into per-cycle register, ALU and bus-drive enables.
module cpu_control_gen #(
    parameter int NREG = 4,
    parameter int RSEL = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Run,
    input  logic [RSEL-1:0] Rx,
    input  logic [RSEL-1:0] Ry,
    input  logic [2:0]      Fun,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic            Entern,
    output logic [2:0]      AluOp,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [2:0] FUN_LOAD = 3'b000;
    localparam logic [2:0] FUN_MOVE = 3'b001;
    localparam logic [2:0] FUN_ILL  = 3'b111;

    state_t          state;
    logic [2:0]      fun_q;
    logic [RSEL-1:0] rx_q;
    logic [RSEL-1:0] ry_q;

    function automatic logic [NREG-1:0] dec(input logic [RSEL-1:0] sel);
        logic [NREG-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            fun_q  <= '0;
            rx_q   <= '0;
            ry_q   <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
            Entern <= 1'b0;
            AluOp  <= '0;
            Ain    <= 1'b0;
            Gin    <= 1'b0;
            Gout   <= 1'b0;
            Rout   <= '0;
            Rin    <= '0;
        end else begin
            // NOTE: pulses and enables default to 0 here; a later assignment in
            // the case below overrides it, so every step only lists what is on.
            Done   <= 1'b0;
            Err    <= 1'b0;
            Entern <= 1'b0;
            Ain    <= 1'b0;
            Gin    <= 1'b0;
            Gout   <= 1'b0;
            Rout   <= '0;
            Rin    <= '0;

            case (state)
                IDLE: begin
                    if (Run) begin
                        fun_q <= Fun;
                        rx_q  <= Rx;
                        ry_q  <= Ry;
                        case (Fun)
                            FUN_LOAD: begin
                                Rin    <= dec(Rx);
                                Entern <= 1'b1;
                                Busy   <= 1'b1;
                                state  <= T1;
                            end
                            FUN_MOVE: begin
                                Rout  <= dec(Ry);
                                Busy  <= 1'b1;
                                state <= T1;
                            end
                            FUN_ILL: begin
                                Err  <= 1'b1;
                                Done <= 1'b1;
                            end
                            default: begin
                                Rout  <= dec(Rx);
                                Ain   <= 1'b1;
                                Busy  <= 1'b1;
                                state <= T1;
                            end
                        endcase
                    end
                end

                T1: begin
                    case (fun_q)
                        FUN_LOAD: begin
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end
                        FUN_MOVE: begin
                            Rin   <= dec(rx_q);
                            state <= T2;
                        end
                        default: begin
                            Rout  <= dec(ry_q);
                            Gin   <= 1'b1;
                            AluOp <= fun_q - 3'd2;
                            state <= T2;
                        end
                    endcase
                end

                T2: begin
                    if (fun_q == FUN_MOVE) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Gout  <= 1'b1;
                        Rin   <= dec(rx_q);
                        state <= T3;
                    end
                end

                T3: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_control_gen.md
CPU_CONTROL_GEN -- requirements
Module: cpu_control_gen

Interface
REQ-001 Parameter: NREG, 4, number of general registers; legal values 2, 4, 8, 16.
REQ-002 Parameter: RSEL, $clog2(NREG), derived register-select width; not overridden by users.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Run  input  1  start request; sampled only in IDLE.
REQ-006 Rx  input  RSEL  destination register (first operand for ALU ops).
REQ-007 Ry  input  RSEL  source register (second operand for ALU ops).
REQ-008 Fun  input  3  opcode: 000 load, 001 move, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 illegal.
REQ-009 Busy  output  1  instruction in progress.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Err  output  1  one-cycle pulse on illegal opcode.
REQ-012 Entern  output  1  external data drives bus.
REQ-013 AluOp  output  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor.
REQ-014 Ain, Gin, Gout  output  1 each  A load, G load, G drives bus.
REQ-015 Rout  output  NREG  per-register bus-drive enables.
REQ-016 Rin  output  NREG  per-register load enables.

Function
REQ-017 All outputs SHALL be registered; single FSM with states IDLE, T1, T2, T3.
REQ-018 In IDLE with Run=1 at edge k, Fun/Rx/Ry SHALL be latched; later input changes SHALL not affect the instruction.
REQ-019 Run SHALL be ignored while Busy=1; no queuing.
REQ-020 Busy SHALL be 1 from edge k until the edge on which Done asserts, where it SHALL drop to 0.
REQ-021 Load: edge k -> Rin[Rx]=1, Entern=1, state T1; edge k+1 -> Rin=0, Entern=0, Done=1, IDLE.
REQ-022 Move: edge k -> Rout[Ry]=1, T1; k+1 -> Rout=0, Rin[Rx]=1, T2; k+2 -> Rin=0, Done=1, IDLE.
REQ-023 ALU (Fun 010-110): edge k -> Rout[Rx]=1, Ain=1, T1; k+1 -> Rout[Rx]=0, Rout[Ry]=1, Ain=0, Gin=1, AluOp set, T2; k+2 -> Rout=0, Gin=0, Gout=1, Rin[Rx]=1, T3; k+3 -> Gout=0, Rin=0, Done=1, IDLE.
REQ-024 AluOp SHALL equal Fun-2 for ALU ops, hold from k+1 through k+3, and otherwise hold its last value.
REQ-025 Illegal Fun=111 at edge k: Err=1 and Done=1 for one cycle, Busy stays 0, no enables asserted, remain IDLE.
REQ-026 Done and Err SHALL deassert on the edge after assertion; a new Run SHALL be accepted on that same edge.
REQ-027 Rout and Rin SHALL each be zero or one-hot at all times.
REQ-028 Bus drivers (any Rout bit, Gout, Entern) SHALL never be asserted simultaneously.
REQ-029 Rx=Ry SHALL be legal: move is a no-op copy; ALU computes Rx op Rx.
REQ-030 Unreachable state encodings SHALL return to IDLE with all enables 0.

Reset
REQ-031 reset=1 SHALL immediately force IDLE and all outputs to 0, including AluOp=000.
REQ-032 Reset mid-instruction SHALL abort it with no Done pulse; the first Run after release SHALL start a fresh instruction.

Verification
REQ-033 NREG=4, Run with Fun=000, Rx=2 -> Rin=0100 and Entern=1 for one cycle; then Done pulse and Busy=0 after 2 edges.
REQ-034 NREG=8, Fun=011, Rx=5, Ry=3 -> Rout=0x20 with Ain, then Rout=0x08 with Gin and AluOp=001, then Gout with Rin=0x20; Done at edge k+3.
REQ-035 Fun=111 -> single-cycle Err=1 and Done=1; all enables 0; Busy 0.
REQ-036 During an ALU op, pulse Run and change Fun/Rx -> no effect on sequence; Run held high after Done -> next op starts on the following edge.
REQ-037 Assert reset at T2 of a move -> all outputs 0 immediately, no Done; subsequent load completes normally.
REQ-038 Random opcodes over NREG=2 and NREG=16 -> assertions for one-hot Rout/Rin and bus-driver exclusivity never fire.
